e203_sleep_ctrl: RTL and testbench
==================================

# e203_sleep_ctrl

Always-on sleep/wake sequencer that drives the `core_wfi` input of the core clock controller. It accepts a WFI request from the commit stage and waits for IFU, LSU and BIU to drain before asserting `core_wfi`. On an interrupt or debug request it deasserts `core_wfi`, holds for a programmable clock-settle delay, then releases the core with a wake pulse. It runs on the always-on clock and also keeps a saturating count of cycles spent in the last sleep.

## Interface
- `WAKE_DLY`, 4: cycles spent in WAKE between `core_wfi` deassertion and `wake_pulse`; legal range 1..15.
- `CNT_W`, 16: width of the sleep-cycle counter.

Ports:
- `clk`  in  1  always-on clock (the clock controller's `clk_aon`).
- `rst`  in  1  reset; synchronous, active-high.
- `wfi_req`  in  1  level from commit; held high until `wfi_ack` or `wake_pulse`; may drop early to abort.
- `ifu_idle`  in  1  IFU has no outstanding fetch.
- `lsu_idle`  in  1  LSU has no outstanding access.
- `biu_idle`  in  1  BIU has no outstanding bus transaction.
- `irq_pend`  in  1  an enabled interrupt is pending (wake source).
- `dbg_req`  in  1  debug halt request (wake source).
- `core_wfi`  out  1  registered; high only in SLEEP.
- `wfi_ack`  out  1  registered one-cycle pulse in the first SLEEP cycle.
- `wake_pulse`  out  1  registered one-cycle pulse when WAKE completes or a DRAIN is woken.
- `sleep_cycles`  out  CNT_W  cycles spent in the current or most recent SLEEP; saturates at all-ones.

## Operation
- Wake source: `wake = irq_pend | dbg_req`. Drain complete: `drained = ifu_idle & lsu_idle & biu_idle`.
- **IDLE**
  - `wfi_req & ~wake_pulse` → DRAIN.
  - `wfi_req` is ignored in the cycle `wake_pulse` is high.
- **DRAIN**, priority order:
  - `~wfi_req` → IDLE, no pulses (abort).
  - Else `wake` → IDLE with `wake_pulse`; clocks were never gated, so no settle delay.
  - Else `drained` → SLEEP with `wfi_ack`; `sleep_cycles` cleared to 0.
  - Else stay in DRAIN; no timeout.
- **SLEEP**
  - `core_wfi=1`; `sleep_cycles` increments by 1 each cycle, saturating.
  - `wake` → WAKE; wake counter loaded with `WAKE_DLY-1`.
  - `wfi_req` and the idle inputs are ignored.
- **WAKE**
  - `core_wfi=0`; counter decrements each cycle.
  - At 0 → IDLE with `wake_pulse`.
  - Wake sources are ignored in this state.
- `sleep_cycles` holds its value outside SLEEP and is cleared only on DRAIN→SLEEP.

## Timing
- Reset: state IDLE; `core_wfi`, `wfi_ack` and `wake_pulse` are 0; `sleep_cycles` is 0; wake counter is 0.
- Reset asserted in any state: IDLE and all outputs 0 at the next edge, including mid-SLEEP.
- All outputs are registered; each reflects the state entered at the preceding edge.
- Entry latency:
  - `wfi_req` high in cycle 0 → DRAIN in cycle 1.
  - If `drained & ~wake` in cycle 1 → SLEEP in cycle 2, with `core_wfi=1` and `wfi_ack=1` in cycle 2.
  - Minimum entry latency is 2 cycles.
- Exit latency:
  - `wake` in SLEEP cycle n → `core_wfi=0` in cycle n+1.
  - WAKE lasts exactly `WAKE_DLY` cycles.
  - `wake_pulse=1` in IDLE cycle n+1+`WAKE_DLY`.
- Simultaneous events in DRAIN:
  - Abort beats wake.
  - Wake beats drain completion.
  - A one-cycle wake glitch in DRAIN still produces `wake_pulse`.
- `wfi_ack` and `wake_pulse` are never high in the same cycle.

## Structure
- Package `e203_sleep_pkg`:
  - `sleep_state_e` typedef (IDLE, DRAIN, SLEEP, WAKE), 2-bit encoding.
  - `WAKE_DLY_MAX` = 15.
  - Wake counter width constant = 4.
- One sub-module `e203_sleep_satcnt`: parameterized-width saturating up-counter with synchronous clear and enable; used for `sleep_cycles`.
- The FSM and wake down-counter stay in the top module.

## Test plan
- Basic cycle:
  - Stimulus: idles all 1, `wfi_req` rises in cycle 0; `irq_pend` pulses in cycle 10.
  - Required: `core_wfi` and `wfi_ack` high in cycle 2; `core_wfi` low in cycle 11; `wake_pulse` in cycle 15 (`WAKE_DLY=4`); `sleep_cycles` = 9.
- Drain stall:
  - Stimulus: `lsu_idle` held 0 until cycle 6.
  - Required: stays in DRAIN with `core_wfi=0`; SLEEP entered in cycle 7.
- Wake during drain:
  - Stimulus: `dbg_req` in cycle 3 while `biu_idle=0`.
  - Required: `wake_pulse` in cycle 4; `core_wfi` never high; `wfi_ack` never high.
- Abort:
  - Stimulus: `wfi_req` drops in cycle 2 while draining; `irq_pend` also high in cycle 2.
  - Required: IDLE in cycle 3; no `wake_pulse`; no `wfi_ack`.
- Saturation:
  - Stimulus: `CNT_W=4`, sleep for 40 cycles.
  - Required: `sleep_cycles`=15 held through WAKE and IDLE; cleared to 0 on the next SLEEP entry.
- Reset mid-operation:
  - Stimulus: `rst` pulsed in SLEEP cycle 5, then in WAKE on the next sleep.
  - Required: each time, all outputs 0 at the next edge; state IDLE; no `wake_pulse` afterward.

Source files
------------

// File: rtl/e203_sleep_pkg.sv
// Shared types and constants for the always-on sleep/wake sequencer.
package e203_sleep_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StSleep = 2'd2,
    StWake  = 2'd3
  } sleep_state_e;

  localparam int unsigned WAKE_DLY_MAX = 15;
  localparam int unsigned WAKE_CNT_W   = 4;

endpackage

// File: rtl/e203_sleep_satcnt.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module e203_sleep_satcnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/e203_sleep_ctrl.sv
// Always-on sleep/wake sequencer: drains the core before gating, then applies a
// clock-settle delay before releasing it with a wake pulse.
module e203_sleep_ctrl
  import e203_sleep_pkg::*;
#(
  parameter int unsigned WAKE_DLY = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wfi_req,
  input  logic             ifu_idle,
  input  logic             lsu_idle,
  input  logic             biu_idle,
  input  logic             irq_pend,
  input  logic             dbg_req,
  output logic             core_wfi,
  output logic             wfi_ack,
  output logic             wake_pulse,
  output logic [CNT_W-1:0] sleep_cycles
);

  sleep_state_e state_q, state_d;
  logic [WAKE_CNT_W-1:0] wcnt_q, wcnt_d;
  logic core_wfi_q, core_wfi_d;
  logic wfi_ack_q, wfi_ack_d;
  logic wake_pulse_q, wake_pulse_d;

  logic wake, drained;
  assign wake    = irq_pend | dbg_req;
  assign drained = ifu_idle & lsu_idle & biu_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      core_wfi_q   <= 1'b0;
      wfi_ack_q    <= 1'b0;
      wake_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      core_wfi_q   <= core_wfi_d;
      wfi_ack_q    <= wfi_ack_d;
      wake_pulse_q <= wake_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      // A request seen alongside the previous wake pulse is stale.
      StIdle: if (wfi_req && !wake_pulse_q) state_d = StDrain;
      StDrain: begin
        if (!wfi_req || wake) state_d = StIdle;
        else if (drained)     state_d = StSleep;
      end
      StSleep: begin
        if (wake) begin
          state_d = StWake;
          wcnt_d  = WAKE_CNT_W'(WAKE_DLY - 1);
        end
      end
      StWake: begin
        if (wcnt_q == '0) state_d = StIdle;
        else              wcnt_d  = wcnt_q - WAKE_CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_wfi_d   = (state_d == StSleep);
    wfi_ack_d    = (state_q == StDrain) && (state_d == StSleep);
    // Abort (wfi_req low) takes priority over a wake seen in DRAIN.
    wake_pulse_d = ((state_q == StDrain) && wfi_req && wake) ||
                   ((state_q == StWake) && (wcnt_q == '0));
  end

  e203_sleep_satcnt #(
    .Width(CNT_W)
  ) u_sleep_cnt (
    .clk(clk),
    .rst(rst),
    .clr(wfi_ack_d),
    .en (state_q == StSleep),
    .cnt(sleep_cycles)
  );

  assign core_wfi   = core_wfi_q;
  assign wfi_ack    = wfi_ack_q;
  assign wake_pulse = wake_pulse_q;

endmodule

// File: tb/tb_e203_sleep_ctrl.sv
// Directed bench for e203_sleep_ctrl; expected outputs queued per cycle and
// checked one edge later.
module tb_e203_sleep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wfi_req = 1'b0;
  logic ifu_idle = 1'b1, lsu_idle = 1'b1, biu_idle = 1'b1;
  logic irq_pend = 1'b0, dbg_req = 1'b0;
  logic core_wfi, wfi_ack, wake_pulse;
  logic [3:0] sleep_cycles;

  e203_sleep_ctrl #(
    .WAKE_DLY(4),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wfi_req     (wfi_req),
    .ifu_idle    (ifu_idle),
    .lsu_idle    (lsu_idle),
    .biu_idle    (biu_idle),
    .irq_pend    (irq_pend),
    .dbg_req     (dbg_req),
    .core_wfi    (core_wfi),
    .wfi_ack     (wfi_ack),
    .wake_pulse  (wake_pulse),
    .sleep_cycles(sleep_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         test;
    int         cyc;
    logic       cw;
    logic       ack;
    logic       wp;
    logic [3:0] sc;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic string tname(int t);
    case (t)
      0: return "reset";
      1: return "basic";
      2: return "stall";
      3: return "drainwake";
      4: return "abort";
      5: return "satur";
      6: return "rst_sleep";
      7: return "rst_wake";
      default: return "misc";
    endcase
  endfunction

  function automatic logic [3:0] cap(int v, int lim);
    return 4'((v > lim) ? lim : v);
  endfunction

  task automatic push(input int t, input int c, input logic cw, input logic ack,
                      input logic wp, input logic [3:0] sc);
    exp_t e;
    e = '{test: t, cyc: c, cw: cw, ack: ack, wp: wp, sc: sc};
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (core_wfi === e.cw) else begin
        n_fail++;
        $error("FAIL %s@%0d core_wfi got %b want %b", tname(e.test), e.cyc, core_wfi, e.cw);
      end
      n_assert++;
      assert (wfi_ack === e.ack) else begin
        n_fail++;
        $error("FAIL %s@%0d wfi_ack got %b want %b", tname(e.test), e.cyc, wfi_ack, e.ack);
      end
      n_assert++;
      assert (wake_pulse === e.wp) else begin
        n_fail++;
        $error("FAIL %s@%0d wake_pulse got %b want %b", tname(e.test), e.cyc, wake_pulse,
               e.wp);
      end
      n_assert++;
      assert (sleep_cycles === e.sc) else begin
        n_fail++;
        $error("FAIL %s@%0d sleep_cycles got %0d want %0d", tname(e.test), e.cyc,
               sleep_cycles, e.sc);
      end
    end
    n_assert++;
    assert (!(wfi_ack === 1'b1 && wake_pulse === 1'b1)) else begin
      n_fail++;
      $error("FAIL ack_wp_overlap got both high want exclusive");
    end
  endtask

  initial begin
    int c;
    // Reset
    rst = 1'b1;
    push(0, 0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b0;
    push(0, 1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();

    // Basic: SLEEP cycles 2..10, wake pulse at 10+1+4
    for (int k = 0; k <= 16; k++) begin
      c = k + 1;
      wfi_req  = (k <= 2);
      irq_pend = (k == 10);
      push(1, c, (c >= 2 && c <= 10), (c == 2), (c == 15), (c < 2) ? 4'd0 : cap(c - 2, 9));
      tick();
    end
    irq_pend = 1'b0;

    // Drain stall: lsu busy until cycle 6, SLEEP from cycle 7, wake in cycle 9
    for (int k = 0; k <= 15; k++) begin
      c = k + 1;
      wfi_req  = (k <= 7);
      lsu_idle = (k >= 6);
      irq_pend = (k == 9);
      push(2, c, (c >= 7 && c <= 9), (c == 7), (c == 14),
           (c < 7) ? 4'd9 : cap(c - 7, 3));
      tick();
    end
    irq_pend = 1'b0;
    lsu_idle = 1'b1;

    // Wake during drain: never gated, pulse one cycle after dbg_req
    for (int k = 0; k <= 7; k++) begin
      c = k + 1;
      biu_idle = 1'b0;
      wfi_req  = (k <= 4);
      dbg_req  = (k == 3);
      push(3, c, 1'b0, 1'b0, (c == 4), 4'd3);
      tick();
    end
    dbg_req  = 1'b0;
    biu_idle = 1'b1;

    // Abort beats a simultaneous interrupt
    for (int k = 0; k <= 5; k++) begin
      c = k + 1;
      ifu_idle = 1'b0;
      wfi_req  = (k <= 1);
      irq_pend = (k == 2);
      push(4, c, 1'b0, 1'b0, 1'b0, 4'd3);
      tick();
    end
    irq_pend = 1'b0;
    ifu_idle = 1'b1;

    // Saturation: 40 SLEEP cycles (2..41)
    for (int k = 0; k <= 47; k++) begin
      c = k + 1;
      wfi_req  = (k <= 2);
      irq_pend = (k == 41);
      push(5, c, (c >= 2 && c <= 41), (c == 2), (c == 46), (c < 2) ? 4'd3 : cap(c - 2, 15));
      tick();
    end
    irq_pend = 1'b0;

    // Next sleep clears the count; reset in its fifth SLEEP cycle
    for (int k = 0; k <= 12; k++) begin
      c = k + 1;
      wfi_req  = (k <= 2);
      rst      = (k == 6);
      irq_pend = (k == 9);
      if (c < 2)       push(6, c, 1'b0, 1'b0, 1'b0, 4'd15);
      else if (c <= 6) push(6, c, 1'b1, (c == 2), 1'b0, 4'(c - 2));
      else             push(6, c, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
    end
    rst      = 1'b0;
    irq_pend = 1'b0;

    // Reset during WAKE (WAKE cycles 6..9); the pulse due at 10 must not appear
    for (int k = 0; k <= 14; k++) begin
      c = k + 1;
      wfi_req  = (k <= 2);
      irq_pend = (k == 5);
      rst      = (k == 7);
      push(7, c, (c >= 2 && c <= 5), (c == 2), 1'b0,
           (c < 2 || c >= 8) ? 4'd0 : cap(c - 2, 4));
      tick();
    end
    rst      = 1'b0;
    irq_pend = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
